debounce_sync: RTL and testbench

Input conditioning stage for the push-button path. It takes the raw asynchronous `pulsador` pin, synchronises it into the `clk` domain and removes contact bounce with a stable-time state machine. It emits a clean level plus one-cycle rise/fall strobes. Its outputs feed the downstream LED press-counter logic inside `top`, which consumes `btn_rise`.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_sync_sync_ff.sv | 23 ++
 rtl/debounce_sync.sv | 116 +++++++++++
 tb/tb_debounce_sync.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button conditioning path.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_LOW_CHK  = 2'd1,
    S_HIGH     = 2'd2,
    S_HIGH_CHK = 2'd3
  } db_state_t;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 32'd54000;
  localparam int unsigned CLK_FREQ_HZ           = 32'd27_000_000;

  // Counter width for a stable-time qualifier; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 32'd2) ? 32'd1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_sync_sync_ff.sv
// Multi-stage synchroniser for an asynchronous single-bit pin; q is the last stage.
module sync_ff #(
  parameter int unsigned STAGES = 32'd2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises the raw button pin and accepts a new level only after it has
// held for STABLE_CYCLES consecutive clocks; emits one-cycle rise/fall strobes.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = 32'd2
) (
  input  logic clk,
  input  logic rst,
  input  logic pulsador,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic             sync_s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pulsador),
    .q  (sync_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The count includes the edge that first sees the opposite level, so the
  // check states accept when cnt already shows STABLE_CYCLES-1 prior samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_s) begin
          state_d = S_LOW_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_LOW_CHK: begin
        if (!sync_s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_s) begin
          state_d = S_HIGH_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_HIGH_CHK: begin
        if (sync_s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench: a run-length reference model queues the expected outputs
// per clock; a monitor pops and compares them on the falling edge.
module tb_debounce_sync;

  localparam int S  = 8;
  localparam int SS = 2;

  logic clk;
  logic rst;
  logic pulsador;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  int tests = 0;
  int fails = 0;

  logic [2:0] exp_q[$];
  int         strobe_log[$];
  int         dut_rises = 0;
  int         dut_falls = 0;

  debounce_sync #(
    .STABLE_CYCLES(S),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulsador (pulsador),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #18 clk = 1'b1;
      #19 clk = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the pin reaches the decision logic SS clocks late; the level
  // flips once it has disagreed with the current level for S straight clocks.
  initial begin : model
    logic shq[$];
    logic lvl, r, f, s;
    int   run;
    lvl = 1'b0;
    run = 0;
    for (int i = 0; i < SS; i++) shq.push_back(1'b0);
    forever begin
      @(posedge clk);
      r = 1'b0;
      f = 1'b0;
      if (rst) begin
        shq.delete();
        for (int i = 0; i < SS; i++) shq.push_back(1'b0);
        lvl = 1'b0;
        run = 0;
      end else begin
        s = shq[0];
        if (s != lvl) begin
          run++;
          if (run == S) begin
            lvl = ~lvl;
            r   = lvl;
            f   = ~lvl;
            run = 0;
          end
        end else begin
          run = 0;
        end
        shq.push_back(pulsador);
        void'(shq.pop_front());
      end
      exp_q.push_back({lvl, r, f});
    end
  end

  initial begin : monitor
    logic [2:0] e;
    int         cyc;
    int         last_strobe;
    cyc = 0;
    last_strobe = -1000;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("outputs{level,rise,fall}", int'({btn_level, btn_rise, btn_fall}), int'(e));
        if (btn_rise === 1'b1 || btn_fall === 1'b1) begin
          chk("rise_fall_exclusive", int'(btn_rise & btn_fall), 0);
          chk("strobe_spacing_ok", int'((cyc - last_strobe) >= S), 1);
          last_strobe = cyc;
          if (btn_rise === 1'b1) begin
            dut_rises++;
            strobe_log.push_back(1);
          end else begin
            dut_falls++;
            strobe_log.push_back(2);
          end
        end
      end
    end
  end

  task automatic cyc(input logic p, input logic r);
    pulsador = p;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic p, input int n);
    for (int i = 0; i < n; i++) cyc(p, 1'b0);
  endtask

  // Holds p for n clocks; idx is the clock number (1-based) of the first rise.
  task automatic hold_rise(input logic p, input int n, output int idx, output int hi);
    idx = 0;
    hi  = 0;
    for (int i = 1; i <= n; i++) begin
      cyc(p, 1'b0);
      if (btn_rise === 1'b1) begin
        hi++;
        if (idx == 0) idx = i;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin : driver
    int idx, hi, r0, f0;
    pulsador = 1'b0;
    rst      = 1'b1;

    // 1: reset held with the button pressed, then re-qualified press
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1);
      chk("t1_outputs_in_reset", int'({btn_level, btn_rise, btn_fall}), 0);
    end
    settle();
    r0 = dut_rises;
    hold_rise(1'b1, 20, idx, hi);
    settle();
    chk("t1_rise_edge", idx, 10);
    chk("t1_rise_count", dut_rises - r0, 1);
    chk("t1_level_high", int'(btn_level), 1);

    // 2: clean press from reset idle
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    hold(1'b0, 12);
    settle();
    r0 = dut_rises;
    hold_rise(1'b1, 20, idx, hi);
    settle();
    chk("t2_rise_edge", idx, 10);
    chk("t2_rise_width", hi, 1);
    chk("t2_rise_count", dut_rises - r0, 1);

    // 3: bouncing press
    hold(1'b0, 15);
    settle();
    chk("t3_level_low_before", int'(btn_level), 0);
    r0 = dut_rises;
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 5);
    hold(1'b0, 1);
    hold_rise(1'b1, 20, idx, hi);
    settle();
    chk("t3_rise_edge", idx, 10);
    chk("t3_rise_count", dut_rises - r0, 1);

    // 4: low glitches from the high level, just short and exactly long enough
    f0 = dut_falls;
    hold(1'b0, S - 1);
    hold(1'b1, 20);
    settle();
    chk("t4_short_glitch_falls", dut_falls - f0, 0);
    chk("t4_level_kept", int'(btn_level), 1);
    f0 = dut_falls;
    hold(1'b0, S);
    hold(1'b1, 20);
    settle();
    chk("t4_long_glitch_falls", dut_falls - f0, 1);

    // 5: reset mid-qualification with cnt at 5
    hold(1'b0, 15);
    hold(1'b1, 7);
    settle();
    r0 = dut_rises;
    f0 = dut_falls;
    cyc(1'b1, 1'b1);
    chk("t5_outputs_after_reset", int'({btn_level, btn_rise, btn_fall}), 0);
    hold_rise(1'b1, 20, idx, hi);
    settle();
    chk("t5_rise_edge", idx, 10);
    chk("t5_no_fall_from_reset", dut_falls - f0, 0);
    chk("t5_rise_count", dut_rises - r0, 1);

    // 6: two bouncing press/release cycles
    hold(1'b0, 15);
    settle();
    strobe_log.delete();
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
      hold(1'b1, 12);
      cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
      hold(1'b0, 12);
    end
    hold(1'b0, 4);
    settle();
    chk("t6_strobe_count", strobe_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t6_strobe_order", strobe_log[i], (i % 2 == 0) ? 1 : 2);

    // Random bursts with occasional resets, checked by the model
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 19) == 0) begin
        cyc(1'($urandom_range(0, 1)), 1'b1);
      end else begin
        hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      end
    end
    hold(1'b0, 3);
    settle();
    chk("queue_drained", int'(exp_q.size() <= 1), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
